// File: rtl/mips_mem_pkg.sv
// Shared constants for the mips data-side responder: MMIO register offsets,
// STATUS bit positions and the default MMIO window base.
package mips_mem_pkg;

   localparam logic [1:0] OFF_CYCLE  = 2'd0;
   localparam logic [1:0] OFF_STORE  = 2'd1;
   localparam logic [1:0] OFF_LED    = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   localparam int ST_MISALIGN = 0;
   localparam int ST_UNMAPPED = 1;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_NONE
   } region_e;

endpackage

// File: rtl/mips_dmem_ram.sv
// Word RAM behind the data responder: asynchronous read, synchronous write.
// Contents are deliberately not reset so data survives a mid-run reset.
module mips_dmem_ram #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [31:0]              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle mips core: address decode, word
// RAM, MMIO bank (cycle/store counters, LED register, sticky W1C status).
module mips_dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   parameter int          LED_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic [31:0]      aluout,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] led,
   output logic             err
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

   region_e        region;
   logic           aligned;
   logic [1:0]     offset;
   logic [AW-1:0]  word_idx;
   logic           ram_we;
   logic [31:0]    ram_rdata;

   logic [31:0]    cycle_cnt;
   logic [31:0]    store_cnt;
   logic [31:0]    led_reg;
   logic [1:0]     status;

   always_comb begin
      region = REGION_NONE;
      if (aluout < RAM_BYTES)
         region = REGION_RAM;
      else if (aluout[31:4] == MMIO_BASE[31:4])
         region = REGION_MMIO;
   end

   assign aligned  = (aluout[1:0] == 2'b00);
   assign offset   = aluout[3:2];
   assign word_idx = aluout[AW+1:2];

   // reset gates the RAM port too: no store of any kind commits while held
   assign ram_we = memwrite && aligned && (region == REGION_RAM) && !reset;

   mips_dmem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (word_idx),
      .wdata (writedata),
      .raddr (word_idx),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         store_cnt <= '0;
         led_reg   <= '0;
         status    <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (memwrite) begin
            if (!aligned) begin
               status[ST_MISALIGN] <= 1'b1;
            end else begin
               case (region)
                  REGION_RAM: begin
                     if (store_cnt != 32'hFFFF_FFFF) store_cnt <= store_cnt + 32'd1;
                  end
                  REGION_MMIO: begin
                     if (offset == OFF_LED)
                        led_reg <= writedata;
                     else if (offset == OFF_STATUS)
                        status <= status & ~writedata[1:0];
                  end
                  default: status[ST_UNMAPPED] <= 1'b1;
               endcase
            end
         end
      end
   end

   always_comb begin
      readdata = 32'h0;
      case (region)
         REGION_RAM: readdata = ram_rdata;
         REGION_MMIO: begin
            case (offset)
               OFF_CYCLE:  readdata = cycle_cnt;
               OFF_STORE:  readdata = store_cnt;
               OFF_LED:    readdata = led_reg;
               default:    readdata = {30'd0, status};
            endcase
         end
         default: readdata = 32'h0;
      endcase
   end

   assign led = led_reg[LED_W-1:0];
   assign err = |status;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: directed scenarios plus random
// traffic checked against an address-map level reference model.
module tb_mips_dmem_responder;

   logic        clk = 1'b1;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] aluout = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic [7:0]  led;
   logic        err;

   always #5 clk = ~clk;

   mips_dmem_responder dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .aluout    (aluout),
      .writedata (writedata),
      .readdata  (readdata),
      .led       (led),
      .err       (err)
   );

   // reference model: memory map state as plain variables
   logic [31:0] m_ram [64];
   bit          m_known [64];
   logic [31:0] m_cycle = 0;
   logic [31:0] m_sc = 0;
   logic [31:0] m_led = 0;
   logic [1:0]  m_st = 0;

   typedef struct {
      logic [31:0] rd;
      logic [7:0]  led;
      logic        err;
      string       name;
   } exp_t;

   exp_t q[$];
   bit   chk_valid = 1'b0;
   int   checks = 0;
   int   errors = 0;

   function automatic bit is_mmio(logic [31:0] a);
      return (a >> 4) == 32'h0FFF_FFF0;
   endfunction

   function automatic logic [31:0] model_read(logic [31:0] a);
      if (a < 32'd256) return m_ram[a[7:2]];
      if (is_mmio(a)) begin
         case ((a >> 2) & 32'd3)
            32'd0:   return m_cycle;
            32'd1:   return m_sc;
            32'd2:   return m_led;
            default: return {30'd0, m_st};
         endcase
      end
      return 32'h0;
   endfunction

   function automatic bit readable(logic [31:0] a);
      if (a < 32'd256) return m_known[a[7:2]];
      return 1'b1;
   endfunction

   task automatic model_store(logic [31:0] a, logic [31:0] d);
      if ((a % 4) != 0) m_st[0] = 1'b1;
      else if (a < 32'd256) begin
         m_ram[a[7:2]]   = d;
         m_known[a[7:2]] = 1'b1;
         if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else if (is_mmio(a)) begin
         if (((a >> 2) & 32'd3) == 32'd2) m_led = d;
         else if (((a >> 2) & 32'd3) == 32'd3) m_st = m_st & ~d[1:0];
      end else m_st[1] = 1'b1;
   endtask

   // issue one bus cycle; expected combinational response is queued first
   task automatic do_op(bit we, logic [31:0] a, logic [31:0] d, string name);
      memwrite  = we;
      aluout    = a;
      writedata = d;
      if (readable(a)) begin
         q.push_back('{model_read(a), m_led[7:0], (m_st != 2'b00), name});
         chk_valid = 1'b1;
      end else chk_valid = 1'b0;
      @(posedge clk);
      if (!reset) begin
         m_cycle = m_cycle + 1;
         if (we) model_store(a, d);
      end
      #1;
      chk_valid = 1'b0;
      memwrite  = 1'b0;
   endtask

   task automatic model_reset();
      m_cycle = 0; m_sc = 0; m_led = 0; m_st = 0;
   endtask

   always @(negedge clk) begin
      if (chk_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL no_expected: readdata=%h with empty scoreboard", readdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (readdata !== e.rd || led !== e.led || err !== e.err) begin
               errors++;
               $display("FAIL %s: got rd=%h led=%h err=%b, want rd=%h led=%h err=%b",
                        e.name, readdata, led, err, e.rd, e.led, e.err);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int sel;
      bit we;

      // registers read zero during reset
      do_op(0, 32'hFFFF_FF00, 0, "rst_cycle");
      do_op(0, 32'hFFFF_FF04, 0, "rst_store");
      do_op(0, 32'hFFFF_FF08, 0, "rst_led");
      do_op(0, 32'hFFFF_FF0C, 0, "rst_status");
      reset = 1'b0;

      // store then read back; second store sees old data in its own cycle
      do_op(1, 32'h0000_0010, 32'hDEAD_BEEF, "st_10");
      do_op(0, 32'h0000_0010, 0, "rd_10");
      do_op(0, 32'hFFFF_FF04, 0, "store_cnt_1");
      do_op(0, 32'hFFFF_FF00, 0, "cycle_n");
      do_op(1, 32'h0000_0020, 32'h0BAD_F00D, "st_20");
      do_op(1, 32'h0000_0020, 32'h600D_F00D, "same_cycle_old");
      do_op(0, 32'h0000_0020, 0, "rd_20_new");

      // misaligned store suppressed, then W1C clear
      do_op(1, 32'h0000_0012, 32'h1234_5678, "st_misalign");
      do_op(0, 32'h0000_0010, 0, "ram10_unchanged");
      do_op(0, 32'hFFFF_FF0C, 0, "status_misalign");
      do_op(1, 32'hFFFF_FF0C, 32'h1, "w1c_bit0");
      do_op(0, 32'hFFFF_FF0C, 0, "status_cleared");

      // unmapped store
      do_op(1, 32'h0000_1000, 32'hFFFF_FFFF, "st_unmapped");
      do_op(0, 32'h0000_1000, 0, "rd_unmapped");
      do_op(0, 32'hFFFF_FF0C, 0, "status_unmapped");
      do_op(1, 32'hFFFF_FF0C, 32'h3, "w1c_both");
      do_op(0, 32'hFFFF_FF0C, 0, "status_clear2");

      // LED register and read-only counters
      do_op(1, 32'hFFFF_FF08, 32'h0000_01A5, "st_led");
      do_op(0, 32'hFFFF_FF08, 0, "led_readback");
      do_op(1, 32'hFFFF_FF00, 32'h5555_5555, "st_cycle_ro");
      do_op(1, 32'hFFFF_FF04, 32'h5555_5555, "st_store_ro");
      do_op(0, 32'hFFFF_FF00, 0, "cycle_after_ro");
      do_op(0, 32'hFFFF_FF04, 0, "store_after_ro");

      // random traffic over all regions
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 6);
         d   = $urandom;
         we  = ($urandom_range(0, 2) != 0);
         case (sel)
            0, 1: a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            2:    a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            3:    a = 32'hFFFF_FF00 | {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            4:    a = 32'hFFFF_FF00 | 32'($urandom_range(0, 15));
            5:    a = 32'h0000_0100 + 32'($urandom_range(0, 4095)) * 4;
            default: a = {1'b1, 31'($urandom)} & 32'hFFFF_FEFC;
         endcase
         if (sel == 3 && a[3:2] == 2'd3 && $urandom_range(0, 3) != 0) d = 32'h0;
         do_op(we, a, d, "random");
      end

      // reset mid-run with a store pending
      do_op(1, 32'h0000_0010, 32'hA1B2_C3D4, "pre_rst_st10");
      memwrite  = 1'b1;
      aluout    = 32'h0000_0020;
      writedata = 32'h5555_AAAA;
      #2;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      do_op(1, 32'h0000_0020, 32'h7777_8888, "rst_no_commit");
      do_op(0, 32'hFFFF_FF00, 0, "midrst_cycle");
      do_op(0, 32'hFFFF_FF04, 0, "midrst_store");
      do_op(0, 32'hFFFF_FF08, 0, "midrst_led");
      do_op(0, 32'hFFFF_FF0C, 0, "midrst_status");
      do_op(0, 32'h0000_0020, 0, "ram20_kept");
      reset = 1'b0;
      do_op(0, 32'h0000_0010, 0, "ram10_kept");
      do_op(0, 32'h0000_0020, 0, "ram20_kept2");
      do_op(0, 32'hFFFF_FF00, 0, "cycle_after_rst");

      // store counter saturation
      dut.store_cnt = 32'hFFFF_FFFE;
      m_sc = 32'hFFFF_FFFE;
      do_op(1, 32'h0000_0030, 32'h1, "sat_st1");
      do_op(0, 32'hFFFF_FF04, 0, "sat_max");
      do_op(1, 32'h0000_0034, 32'h2, "sat_st2");
      do_op(1, 32'h0000_0038, 32'h3, "sat_st3");
      do_op(0, 32'hFFFF_FF04, 0, "sat_hold");
      do_op(0, 32'h0000_0038, 0, "sat_ram");

      @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
